disp_arbiter: RTL and testbench
===============================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter HOLD_MS, default 500, meaning ce1ms ticks a grant is held (legal 1..65535).
REQ-002 Port clk  input  1  system clock, all logic on posedge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port ce1ms  input  1  one-cycle 1 ms tick from the display scanner.
REQ-005 Port req  input  4  per-requester display request, level.
REQ-006 Port req_dat  input  64  four 16-bit hex words, requester i at bits [16i+15:16i].
REQ-007 Port req_pt  input  8  four 2-bit decimal-point digit indices, requester i at [2i+1:2i].
REQ-008 Port gnt  output  4  one-hot grant, registered.
REQ-009 Port done  output  4  one-cycle pulse, hold period completed for requester i.
REQ-010 Port disp_dat  output  16  word to the scanner.
REQ-011 Port disp_pt  output  2  decimal-point digit index to the scanner.
REQ-012 Port disp_vld  output  1  high while any grant is active.

Function
REQ-013 FSM states SHALL be IDLE, SHOW, GAP.
- IDLE -> SHOW when req != 0.
- SHOW -> GAP on hold expiry or when the granted req bit drops.
- GAP -> IDLE unconditionally.
REQ-014 In IDLE with req != 0 at edge N, gnt SHALL be one-hot at edge N+1 for the first set req bit at or after rr_ptr, searching upward mod 4.
REQ-015 In SHOW, disp_dat/disp_pt SHALL mirror the granted requester's req_dat/req_pt slice every cycle (registered, 1-cycle latency); in IDLE/GAP they SHALL hold their last value.
REQ-016 disp_vld SHALL equal |gnt.
REQ-017 Hold counter (16 bit) SHALL clear on entry to SHOW and increment on each ce1ms in SHOW.
- Expiry is ce1ms with count == HOLD_MS-1.
- A ce1ms on the grant cycle counts.
REQ-018 On expiry: done[i] pulses for one cycle with the SHOW->GAP transition, gnt clears, rr_ptr <= i+1 mod 4.
REQ-019 If the granted req bit drops before expiry: gnt clears next edge, no done pulse, rr_ptr <= i+1 mod 4, state -> GAP.
REQ-020 Expiry and req drop in the same cycle SHALL be treated as expiry (done pulses).
REQ-021 GAP SHALL last exactly one cycle with gnt == 0, so a continuously requesting single source is re-granted 2 cycles after release.
REQ-022 Changes to non-granted req bits during SHOW SHALL have no effect.

Reset
REQ-023 On rst_n low, asynchronously: state IDLE, rr_ptr 0, counter 0, gnt 0, done 0, disp_dat 16'h0000, disp_pt 0, disp_vld 0.
REQ-024 Reset mid-SHOW SHALL abort without a done pulse; first grant after release follows REQ-014 with rr_ptr 0.

Configuration
REQ-025 Macro DISP_ARB_PRIO_EN.
- Defined: requester 0 is strict priority. req[0] during SHOW of another requester preempts it: gnt -> 0, GAP, then grant 0; the preempted requester gets no done pulse and rr_ptr is left unchanged. In IDLE, req[0] always wins.
- Undefined: pure round-robin, no preemption.

Structure
REQ-026 Package disp_arb_pkg SHALL hold the state enum, NREQ=4, DAT_W=16, PT_W=2.
REQ-027 Sub-module rr_pick4 SHALL implement the combinational rotate-priority pick (req, ptr -> one-hot, valid).

Verification (HOLD_MS=3)
REQ-028 Single requester: req=4'b0010 constant, req_dat[31:16]=16'h1234, ce1ms every 4 cycles.
- Expected: gnt=4'b0010 one cycle later, disp_dat=16'h1234.
- Expected: done[1] on the 3rd tick, gnt=0 for 1 cycle, then re-grant.
REQ-029 Round-robin: req=4'b1111 constant.
- Expected: grants in order 0,1,2,3,0, each with a done pulse.
REQ-030 Early drop: requester 2 granted, req[2] cleared after 1 tick.
- Expected: gnt=0 next edge, done=0, next grant goes to 3 if requested.
REQ-031 Live update: during SHOW of requester 0, req_dat[15:0] steps 16'h0009 -> 16'h0010.
- Expected: disp_dat follows one cycle later.
REQ-032 Async reset: rst_n pulsed low mid-SHOW between clock edges.
- Expected: gnt, disp_vld, disp_dat go to 0 immediately, no done pulse.
REQ-033 With DISP_ARB_PRIO_EN: requester 3 showing, req[0] rises.
- Expected: gnt=0 next edge, gnt=4'b0001 two edges later, no done[3].

Source files
------------

// File: rtl/disp_arb_pkg.sv
// disp_arb_pkg -- shared types and constants for the display arbiter.
//   state_e        : arbiter FSM states (IDLE, SHOW, GAP)
//   NREQ           : number of requesters
//   DAT_W, PT_W    : display word width and decimal-point index width
//   onehot_to_idx  : encode a one-hot grant vector into a requester index
// Optional feature macro used by the arbiter: DISP_ARB_PRIO_EN.
package disp_arb_pkg;

    localparam int NREQ  = 4;
    localparam int DAT_W = 16;
    localparam int PT_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Encode a one-hot vector; an all-zero vector maps to index 0.
    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/disp_arbiter_rr_pick4.sv
// rr_pick4 -- combinational rotate-priority picker for four requesters.
//   req_i   [3:0] : request vector
//   ptr_i   [1:0] : index with highest priority this round
//   gnt_o   [3:0] : one-hot pick, first set req bit at or above ptr_i (mod 4)
//   valid_o       : any request present
module rr_pick4
    import disp_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            valid_o
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            // 2-bit add wraps naturally, giving the mod-4 search order.
            idx = ptr_i + k[1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter -- time-sliced arbiter sharing one display scanner between
// four requesters. A grant is held for HOLD_MS ce1ms ticks or until the
// granted request drops, followed by a one-cycle gap.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ce1ms           : one-cycle 1 ms tick
//   req [3:0]       : level requests
//   req_dat [63:0]  : per-requester 16-bit words
//   req_pt [7:0]    : per-requester 2-bit decimal-point index
//   gnt [3:0]       : registered one-hot grant
//   done [3:0]      : one-cycle pulse when a hold period completes
//   disp_dat, disp_pt, disp_vld : data towards the scanner
//   dbg_state       : current FSM state, for observation
// Handshake: req is a level; a requester keeps req high to stay granted and
// sees gnt as acknowledgement. There is no back-pressure on the scanner side.
// Macro DISP_ARB_PRIO_EN: requester 0 gets strict priority and preempts others.
module disp_arbiter
    import disp_arb_pkg::*;
#(
    parameter int unsigned HOLD_MS = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce1ms,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DAT_W-1:0] req_dat,
    input  logic [NREQ*PT_W-1:0]  req_pt,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [DAT_W-1:0]      disp_dat,
    output logic [PT_W-1:0]       disp_pt,
    output logic                  disp_vld,
    output logic [1:0]            dbg_state
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MS - 1);

    state_e            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [DAT_W-1:0]  dat_q, dat_d;
    logic [PT_W-1:0]   pt_q, pt_d;

    logic [NREQ-1:0]   pick;
    logic              pick_vld;
    logic [1:0]        gnt_idx;
    logic              gnt_live;
    logic              expire;

    rr_pick4 u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick),
        .valid_o (pick_vld)
    );

    assign gnt_idx  = onehot_to_idx(gnt_q);
    assign gnt_live = |(req & gnt_q);
    assign expire   = ce1ms && (cnt_q == HOLD_LAST);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        dat_d    = dat_q;
        pt_d     = pt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
`ifdef DISP_ARB_PRIO_EN
                    gnt_d   = req[0] ? 4'b0001 : pick;
`else
                    gnt_d   = pick;
`endif
                end
            end

            ST_SHOW: begin
                // Mirror the granted slice every cycle so live updates pass through.
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt_q[i]) begin
                        dat_d = req_dat[i*DAT_W +: DAT_W];
                        pt_d  = req_pt[i*PT_W +: PT_W];
                    end
                end
                if (ce1ms) cnt_d = cnt_q + 16'd1;

                // Expiry wins over a simultaneous request drop.
                if (expire) begin
                    state_d  = ST_GAP;
                    gnt_d    = '0;
                    done_d   = gnt_q;
                    rr_ptr_d = gnt_idx + 2'd1;
                end else if (!gnt_live) begin
                    state_d  = ST_GAP;
                    gnt_d    = '0;
                    rr_ptr_d = gnt_idx + 2'd1;
                end
`ifdef DISP_ARB_PRIO_EN
                // Preemption by requester 0 leaves the round-robin pointer alone.
                else if (req[0] && !gnt_q[0]) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                end
`endif
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 2'd0;
            cnt_q    <= 16'd0;
            gnt_q    <= '0;
            done_q   <= '0;
            dat_q    <= '0;
            pt_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            dat_q    <= dat_d;
            pt_q     <= pt_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign disp_dat  = dat_q;
    assign disp_pt   = pt_q;
    assign disp_vld  = |gnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_disp_arbiter.sv
module tb_disp_arbiter;
  import disp_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce1ms = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] req_dat = '0;
  logic [7:0]  req_pt = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [15:0] disp_dat;
  logic [1:0]  disp_pt;
  logic        disp_vld;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;

  logic [3:0] exp_gnt_q[$];
  logic [3:0] exp_done_q[$];
  logic [3:0] prev_gnt = '0;

  // clock / reset block
  always #5 clk = ~clk;

  disp_arbiter #(.HOLD_MS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce1ms     (ce1ms),
    .req       (req),
    .req_dat   (req_dat),
    .req_pt    (req_pt),
    .gnt       (gnt),
    .done      (done),
    .disp_dat  (disp_dat),
    .disp_pt   (disp_pt),
    .disp_vld  (disp_vld),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step(input logic ce);
    ce1ms = ce;
    @(posedge clk);
    #1;
    ce1ms = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    ce1ms = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: grant and done events compared against expected queues
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      check("vld_eq_or_gnt", 32'(disp_vld), 32'(|gnt));
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (gnt != 4'b0 && prev_gnt == 4'b0) begin
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
        else check("gnt_order", 32'(gnt), 32'(exp_gnt_q.pop_front()));
      end
      if (done != 4'b0) begin
        if (exp_done_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
        else check("done_order", 32'(done), 32'(exp_done_q.pop_front()));
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks;
    int ndone;

    // reset state
    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dat", 32'(disp_dat), 32'd0);
    check("rst_pt", 32'(disp_pt), 32'd0);
    check("rst_vld", 32'(disp_vld), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // single requester, tick every 4 cycles
    req_dat[31:16] = 16'h1234;
    req_pt[3:2]    = 2'd3;
    req            = 4'b0010;
    exp_gnt_q.push_back(4'b0010);
    exp_done_q.push_back(4'b0010);
    step(1'b0);
    check("t1_gnt", 32'(gnt), 32'h2);
    check("t1_state", 32'(dbg_state), 32'(ST_SHOW));
    step(1'b0);
    check("t1_dat", 32'(disp_dat), 32'h1234);
    check("t1_pt", 32'(disp_pt), 32'd3);
    ticks = 0;
    for (int c = 0; c < 40; c++) begin
      step(c % 4 == 3);
      if (c % 4 == 3) ticks++;
      if (ticks == 3) break;
      check("t1_hold_gnt", 32'(gnt), 32'h2);
    end
    check("t1_ticks", 32'(ticks), 32'd3);
    check("t1_exp_gnt", 32'(gnt), 32'd0);
    check("t1_exp_done", 32'(done), 32'h2);
    check("t1_exp_state", 32'(dbg_state), 32'(ST_GAP));
    exp_gnt_q.push_back(4'b0010);
    step(1'b0);
    check("t1_gap_gnt", 32'(gnt), 32'd0);
    check("t1_gap_done", 32'(done), 32'd0);
    step(1'b0);
    check("t1_regrant", 32'(gnt), 32'h2);
    req = 4'b0000;
    step(1'b0);
    check("t1_drop_gnt", 32'(gnt), 32'd0);
    repeat (2) step(1'b0);

    // round robin, all requesting, tick every cycle
    do_reset();
    req_dat = 64'h4444_3333_2222_1111;
    foreach (exp_gnt_q[i]) ; // queue should already be drained here
    exp_gnt_q.push_back(4'b0001);  exp_done_q.push_back(4'b0001);
    exp_gnt_q.push_back(4'b0010);  exp_done_q.push_back(4'b0010);
    exp_gnt_q.push_back(4'b0100);  exp_done_q.push_back(4'b0100);
    exp_gnt_q.push_back(4'b1000);  exp_done_q.push_back(4'b1000);
    exp_gnt_q.push_back(4'b0001);  exp_done_q.push_back(4'b0001);
    req   = 4'b1111;
    ndone = 0;
    for (int c = 0; c < 200; c++) begin
      step(1'b1);
      if (done != 4'b0) ndone++;
      if (ndone >= 5) break;
    end
    req = 4'b0000;
    check("t2_ndone", 32'(ndone), 32'd5);
    repeat (3) step(1'b0);
    check("t2_idle_gnt", 32'(gnt), 32'd0);

    // early drop by requester 2, requester 3 next
    do_reset();
    req = 4'b1100;
    exp_gnt_q.push_back(4'b0100);
    step(1'b0);
    check("t3_gnt2", 32'(gnt), 32'h4);
    step(1'b1);
    req = 4'b1000;
    exp_gnt_q.push_back(4'b1000);
    step(1'b0);
    check("t3_drop_gnt", 32'(gnt), 32'd0);
    check("t3_drop_done", 32'(done), 32'd0);
    step(1'b0);
    step(1'b0);
    check("t3_gnt3", 32'(gnt), 32'h8);
    req = 4'b0000;
    repeat (3) step(1'b0);

    // live data update while requester 0 shows
    do_reset();
    req_dat = '0;
    req_dat[15:0] = 16'h0009;
    req = 4'b0001;
    exp_gnt_q.push_back(4'b0001);
    step(1'b0);
    check("t4_gnt0", 32'(gnt), 32'h1);
    step(1'b0);
    check("t4_dat9", 32'(disp_dat), 32'h0009);
    req_dat[15:0] = 16'h0010;
    #1;
    check("t4_dat_hold", 32'(disp_dat), 32'h0009);
    step(1'b0);
    check("t4_dat10", 32'(disp_dat), 32'h0010);

    // asynchronous reset mid-SHOW
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_gnt", 32'(gnt), 32'd0);
    check("t5_vld", 32'(disp_vld), 32'd0);
    check("t5_dat", 32'(disp_dat), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_state", 32'(dbg_state), 32'(ST_IDLE));
    #2;
    rst_n = 1'b1;
    exp_gnt_q.push_back(4'b0001);
    @(posedge clk);
    #1;
    check("t5_regrant", 32'(gnt), 32'h1);
    req = 4'b0000;
    repeat (3) step(1'b0);

    // requester 0 against a showing requester 3
    do_reset();
    req = 4'b1000;
    exp_gnt_q.push_back(4'b1000);
    step(1'b0);
    check("t6_gnt3", 32'(gnt), 32'h8);
    step(1'b1);
    req = 4'b1001;
`ifdef DISP_ARB_PRIO_EN
    exp_gnt_q.push_back(4'b0001);
    step(1'b0);
    check("t6_preempt_gnt", 32'(gnt), 32'd0);
    check("t6_preempt_done", 32'(done), 32'd0);
    step(1'b0);
    step(1'b0);
    check("t6_gnt0", 32'(gnt), 32'h1);
`else
    step(1'b0);
    check("t6_nopreempt", 32'(gnt), 32'h8);
    req = 4'b0001;
    step(1'b0);
    check("t6_drop_gnt", 32'(gnt), 32'd0);
    check("t6_drop_done", 32'(done), 32'd0);
`endif
    req = 4'b0000;
    repeat (4) step(1'b0);

    check("gnt_q_empty", 32'(exp_gnt_q.size()), 32'd0);
    check("done_q_empty", 32'(exp_done_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
